// File: rtl/lsu_seq.sv
// Load/store sequencer: drives a valid/ready data bus, splits word-crossing accesses into two
// beats, and aligns/extends load data. The core is stalled until the access completes or errors.
module lsu_seq #(
   parameter int TIMEOUT_CYC = 256,
   parameter bit SPLIT_EN    = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_vld,
   input  logic        i_mem_wren,
   input  logic [3:0]  i_mask,
   input  logic        i_mem_un,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_st_data,
   output logic        o_stall,
   output logic        o_done,
   output logic        o_err,
   output logic [31:0] o_ld_data,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [3:0]  o_bus_be,
   output logic [31:0] o_bus_wdata,
   input  logic        i_bus_gnt,
   input  logic        i_bus_rvld,
   input  logic [31:0] i_bus_rdata
);

   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE, ERR} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] tmo_cnt;
   logic          wren_q, un_q;
   logic [3:0]    mask_q;
   logic [31:0]   addr_q, st_q, rdata0_q, rdata1_q;

   logic          mask_ok, in_split, busy, beat1, need1, tmo_hit;
   logic [1:0]    off;
   logic [7:0]    be8;
   logic [63:0]   wd64;
   logic [31:0]   rd_sh, ld_ext;

   // Request decode straight from the inputs so IDLE can reject before any bus traffic.
   always_comb begin
      mask_ok  = (i_mask == 4'b0001) || (i_mask == 4'b0011) || (i_mask == 4'b1111);
      in_split = 1'b0;
      case (i_mask)
         4'b1111: in_split = (i_addr[1:0] != 2'd0);
         4'b0011: in_split = (i_addr[1:0] == 2'd3);
         default: in_split = 1'b0;
      endcase
   end

   always_comb begin
      off   = addr_q[1:0];
      be8   = {4'b0000, mask_q} << off;
      wd64  = {32'h0, st_q} << {off, 3'b000};
      need1 = |be8[7:4];
      busy  = (state == REQ0) || (state == RSP0) || (state == REQ1) || (state == RSP1);
      beat1 = (state == REQ1);
      // Last cycle of the budget: anything short of finishing the access aborts.
      tmo_hit = busy && (tmo_cnt == CW'(TIMEOUT_CYC - 2));
   end

   always_comb begin
      rd_sh  = 32'({rdata1_q, rdata0_q} >> {off, 3'b000});
      ld_ext = rd_sh;
      case (mask_q)
         4'b0001: ld_ext = {{24{~un_q & rd_sh[7]}}, rd_sh[7:0]};
         4'b0011: ld_ext = {{16{~un_q & rd_sh[15]}}, rd_sh[15:0]};
         default: ld_ext = rd_sh;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (i_req_vld) begin
               if (!mask_ok || (in_split && !SPLIT_EN)) state_nxt = ERR;
               else                                     state_nxt = REQ0;
            end
         REQ0:
            if (i_bus_gnt) begin
               if (!wren_q)    state_nxt = RSP0;
               else if (need1) state_nxt = REQ1;
               else            state_nxt = DONE;
            end
         RSP0:
            if (i_bus_rvld) state_nxt = need1 ? REQ1 : DONE;
         REQ1:
            if (i_bus_gnt) state_nxt = wren_q ? DONE : RSP1;
         RSP1:
            if (i_bus_rvld) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (tmo_hit && (state_nxt != DONE)) state_nxt = ERR;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         tmo_cnt  <= '0;
         wren_q   <= 1'b0;
         un_q     <= 1'b0;
         mask_q   <= 4'h0;
         addr_q   <= 32'h0;
         st_q     <= 32'h0;
         rdata0_q <= 32'h0;
         rdata1_q <= 32'h0;
      end else begin
         state   <= state_nxt;
         tmo_cnt <= busy ? tmo_cnt + 1'b1 : '0;
         if ((state == IDLE) && i_req_vld) begin
            wren_q <= i_mem_wren;
            un_q   <= i_mem_un;
            mask_q <= i_mask;
            addr_q <= i_addr;
            st_q   <= i_st_data;
         end
         if ((state == RSP0) && i_bus_rvld) rdata0_q <= i_bus_rdata;
         if ((state == RSP1) && i_bus_rvld) rdata1_q <= i_bus_rdata;
      end
   end

   always_comb begin
      o_done      = (state == DONE) || (state == ERR);
      o_err       = (state == ERR);
      o_stall     = i_req_vld && !o_done;
      o_ld_data   = ((state == DONE) && !wren_q) ? ld_ext : 32'h0;
      o_bus_req   = (state == REQ0) || (state == REQ1);
      o_bus_we    = o_bus_req && wren_q;
      o_bus_addr  = 32'h0;
      o_bus_be    = 4'h0;
      o_bus_wdata = 32'h0;
      if (o_bus_req) begin
         o_bus_addr  = {addr_q[31:2], 2'b00} + (beat1 ? 32'd4 : 32'd0);
         o_bus_be    = beat1 ? be8[7:4] : be8[3:0];
         o_bus_wdata = beat1 ? wd64[63:32] : wd64[31:0];
      end
   end

endmodule
